// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and parity helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    // Data narrower than 8 bits is zero-extended, which leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return ^data ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_counter.sv
// uart_tx_ctrl_counter: enabled up-counter that wraps to 0 after MAX_VALUE
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   en_i       in  count enable
//   value_o    out current count
//   overflow_o out high when enabled at MAX_VALUE (the wrap cycle)
module uart_tx_ctrl_counter #(
    parameter int MAX_VALUE = 7,
    parameter int WIDTH     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] value_q, value_d;

    assign overflow_o = en_i && value_q == WIDTH'(MAX_VALUE);
    assign value_d    = !en_i ? value_q : overflow_o ? '0 : value_q + WIDTH'(1);
    assign value_o    = value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: serialises one handshaked byte as start, LSB-first data, optional parity, stop bits
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   tx_data    in  byte to send, sampled on the accept edge
//   tx_valid   in  tx_data is valid
//   tx_ready   out idle, a byte can be accepted
//   tx         out registered serial line, idle high
//   busy       out frame in progress
//   frame_done out one-cycle pulse after the final stop bit
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [BAUD_W-1:0]    baud_val;
    logic [BIT_W-1:0]     bit_val;
    logic                 bit_end, last_bit, accept;

    uart_tx_ctrl_counter #(.MAX_VALUE(CLKS_PER_BIT - 1), .WIDTH(BAUD_W)) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != IDLE),
        .value_o   (baud_val),
        .overflow_o()
    );

    uart_tx_ctrl_counter #(.MAX_VALUE(DATA_BITS - 1), .WIDTH(BIT_W)) u_bit_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q == DATA && bit_end),
        .value_o   (bit_val),
        .overflow_o()
    );

    assign bit_end  = baud_val == BAUD_W'(CLKS_PER_BIT - 1);
    assign last_bit = bit_val == BIT_W'(DATA_BITS - 1);
    assign accept   = tx_valid && state_q == IDLE;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? START : IDLE;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = !(bit_end && last_bit) ? DATA : PARITY_EN != 0 ? PARITY : STOP;
            PARITY:  state_d = bit_end ? STOP : PARITY;
            STOP:    state_d = bit_end && (stop_q || STOP_BITS == 1) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        shreg_d = accept ? tx_data : state_q == DATA && bit_end ? shreg_q >> 1 : shreg_q;
        par_d   = accept ? calc_parity(8'(tx_data), PARITY_ODD != 0) : par_q;
        // Toggles at the end of each stop bit, so it is set while the second stop bit runs.
        stop_d  = state_q == STOP ? stop_q ^ bit_end : 1'b0;
        // tx is registered from the next state so it changes on the same edge as the state.
        tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_q : 1'b1;
        done_d  = state_q == STOP && state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready   = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: random and directed frames on four configurations against a bit-level frame model
module tb_uart_tx_ctrl;

    localparam int CPB    = 4;
    localparam int PE[4]  = '{0, 1, 1, 0};
    localparam int ODD[4] = '{0, 0, 1, 0};
    localparam int SB[4]  = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] valid = 4'h0;
    logic [3:0] ready_w, tx_w, busy_w, done_w;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_ctrl #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(PE[g]),
            .PARITY_ODD(ODD[g]), .STOP_BITS(SB[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_data   (tx_data),
            .tx_valid  (valid[g]),
            .tx_ready  (ready_w[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .frame_done(done_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial bit k of a frame: start, data LSB first, optional parity, then stop (high).
    function automatic logic exp_bit(input logic [7:0] d, input int k, input int pe, input int odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe != 0 && k == 9) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int i, output bit acc, output int waited);
        acc = 0;
        waited = 0;
        while (!acc && waited < 200) begin
            acc = ready_w[i];
            tick();
            waited++;
        end
        check("accept", 32'(acc), 1);
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit hold, input logic [7:0] nxt,
                        output int waited);
        bit acc;
        int nbits;
        nbits = 1 + 8 + PE[i] + SB[i];
        tx_data = d;
        valid[i] = 1'b1;
        wait_accept(i, acc, waited);
        if (!acc) return;
        if (hold) tx_data = nxt;
        else begin
            valid[i] = 1'b0;
            tx_data = 8'($urandom);
        end
        for (int c = 0; c < nbits * CPB; c++) begin
            check($sformatf("tx_bit%0d_inst%0d", c / CPB, i), 32'(tx_w[i]), 32'(exp_bit(d, c / CPB, PE[i], ODD[i])));
            check("busy", 32'(busy_w[i]), 1);
            check("done_low", 32'(done_w[i]), 0);
            if (!hold && c == 2 * CPB) tx_data = 8'($urandom);
            tick();
        end
        check("frame_done", 32'(done_w[i]), 1);
        check("ready_at_done", 32'(ready_w[i]), 1);
        check("tx_idle_at_done", 32'(tx_w[i]), 1);
    endtask

    initial begin
        int  w;
        bit  acc;
        int  i;
        logic [7:0] d;
        repeat (3) tick();
        check("rst_tx", 32'(tx_w), 32'hF);
        check("rst_ready", 32'(ready_w), 32'hF);
        check("rst_busy", 32'(busy_w), 0);
        check("rst_done", 32'(done_w), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_tx", 32'(tx_w), 32'hF);
            check("idle_ready", 32'(ready_w), 32'hF);
            check("idle_busy", 32'(busy_w), 0);
            check("idle_done", 32'(done_w), 0);
        end
        send(0, 8'h55, 0, 8'h00, w);
        tick();
        send(1, 8'h07, 0, 8'h00, w);
        send(2, 8'h07, 0, 8'h00, w);
        send(1, 8'h00, 0, 8'h00, w);
        tick();
        send(0, 8'hA5, 1, 8'h3C, w);
        send(0, 8'h3C, 0, 8'h00, w);
        check("b2b_gap", 32'(w), 1);
        tick();
        check("b2b_single_done", 32'(done_w[0]), 0);
        check("b2b_no_third", 32'(busy_w[0]), 0);
        tx_data = 8'hF0;
        valid[0] = 1'b1;
        wait_accept(0, acc, w);
        valid[0] = 1'b0;
        repeat (17) tick();
        check("mid_data_bit3", 32'(tx_w[0]), 0);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx_w[0]), 1);
        check("abort_ready", 32'(ready_w[0]), 1);
        check("abort_busy", 32'(busy_w[0]), 0);
        check("abort_done", 32'(done_w[0]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            check("post_abort_done", 32'(done_w[0]), 0);
            check("post_abort_tx", 32'(tx_w[0]), 1);
        end
        send(0, 8'h81, 0, 8'h00, w);
        send(3, 8'hFF, 0, 8'h00, w);
        repeat (16) begin
            i = $urandom_range(0, 3);
            d = 8'($urandom);
            send(i, d, 0, 8'h00, w);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("gap_done", 32'(done_w), 0);
                check("gap_tx", 32'(tx_w), 32'hF);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
